// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle sequencer: game tick, datapath strobe, erase/redraw over shared plot port
//
// Purpose: once per game tick, optionally step the paddle datapath, then win the
// shared plot port. While holding it, erase the old paddle row and draw the new one,
// one pixel per granted cycle.
//
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   left, right        button levels, captured when a move sequence starts
//   next_x             registered X0 returned by the paddle datapath
//   gnt                plot-port grant from the framebuffer arbiter
//   pos_x              current paddle left edge (datapath X input)
//   dp_en              one-cycle datapath step strobe
//   dp_left, dp_right  captured button levels for the datapath
//   req                plot-port request, REQ through DRAW
//   plot, vga_x,       pixel write strobe, column, row and colour
//   vga_y, colour
//   busy               sequencer is not idle

module paddle_ctrl #(
    parameter int unsigned PADDLE_W = 40,
    parameter logic [6:0]  PADDLE_Y = 7'd110,
    parameter logic [7:0]  X_INIT   = 8'd70,
    parameter int unsigned TICK_DIV = 833333,
    parameter logic [2:0]  COLOUR   = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       left,
    input  logic       right,
    input  logic [7:0] next_x,
    input  logic       gnt,
    output logic [7:0] pos_x,
    output logic       dp_en,
    output logic       dp_left,
    output logic       dp_right,
    output logic       req,
    output logic       plot,
    output logic [8:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int I_W   = $clog2(PADDLE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_MOVE,
        S_LATCH,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               pending_q, pending_d;
    logic               first_draw_q, first_draw_d;
    logic               mv_l_q, mv_l_d;
    logic               mv_r_q, mv_r_d;
    logic [7:0]         cur_x_q, cur_x_d;
    logic [7:0]         new_x_q, new_x_d;
    logic [I_W-1:0]     i_q, i_d;
    logic               pix_vld_q, pix_vld_d;
    logic [8:0]         vga_x_q, vga_x_d;
    logic [2:0]         colour_q, colour_d;

    logic               tick;
    logic               last_px;
    logic [I_W-1:0]     i_inc;

    assign tick    = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign last_px = (i_q == I_W'(PADDLE_W - 1));
    assign i_inc   = i_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            pending_q    <= 1'b0;
            first_draw_q <= 1'b1;
            mv_l_q       <= 1'b0;
            mv_r_q       <= 1'b0;
            cur_x_q      <= X_INIT;
            new_x_q      <= X_INIT;
            i_q          <= '0;
            pix_vld_q    <= 1'b0;
            vga_x_q      <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            pending_q    <= pending_d;
            first_draw_q <= first_draw_d;
            mv_l_q       <= mv_l_d;
            mv_r_q       <= mv_r_d;
            cur_x_q      <= cur_x_d;
            new_x_q      <= new_x_d;
            i_q          <= i_d;
            pix_vld_q    <= pix_vld_d;
            vga_x_q      <= vga_x_d;
            colour_q     <= colour_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        // Ticks arriving while busy collapse into this single pending bit.
        pending_d    = pending_q | tick;
        first_draw_d = first_draw_q;
        mv_l_d       = mv_l_q;
        mv_r_d       = mv_r_q;
        cur_x_d      = cur_x_q;
        new_x_d      = new_x_q;
        i_d          = i_q;
        pix_vld_d    = pix_vld_q;
        vga_x_d      = vga_x_q;
        colour_d     = colour_q;

        case (state_q)
            S_IDLE: begin
                // The tick itself counts as pending so REQ follows it directly.
                if (pending_q || tick) begin
                    pending_d = 1'b0;
                    if (left || right || first_draw_q) begin
                        state_d = S_REQ;
                        mv_l_d  = left;
                        mv_r_d  = right;
                    end
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // next_x was registered by the datapath on the dp_en edge.
                new_x_d = first_draw_q ? cur_x_q : next_x;
                i_d     = '0;
                if (first_draw_q) begin
                    state_d   = S_DRAW;
                    pix_vld_d = 1'b1;
                    vga_x_d   = 9'(cur_x_q);
                    colour_d  = COLOUR;
                end else if (next_x == cur_x_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_ERASE;
                    pix_vld_d = 1'b1;
                    vga_x_d   = 9'(cur_x_q);
                    colour_d  = 3'b000;
                end
            end
            S_ERASE: begin
                // The presented pixel is consumed only in a granted cycle.
                if (gnt) begin
                    if (last_px) begin
                        state_d  = S_DRAW;
                        i_d      = '0;
                        vga_x_d  = 9'(new_x_q);
                        colour_d = COLOUR;
                    end else begin
                        i_d     = i_inc;
                        vga_x_d = 9'(cur_x_q) + 9'(i_inc);
                    end
                end
            end
            S_DRAW: begin
                if (gnt) begin
                    if (last_px) begin
                        state_d      = S_DONE;
                        pix_vld_d    = 1'b0;
                        cur_x_d      = new_x_q;
                        first_draw_d = 1'b0;
                    end else begin
                        i_d     = i_inc;
                        vga_x_d = 9'(new_x_q) + 9'(i_inc);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pos_x    = cur_x_q;
    assign dp_en    = (state_q == S_MOVE) && !first_draw_q;
    assign dp_left  = mv_l_q;
    assign dp_right = mv_r_q;
    assign req      = (state_q == S_REQ)   || (state_q == S_MOVE) ||
                      (state_q == S_LATCH) || (state_q == S_ERASE) ||
                      (state_q == S_DRAW);
    // A held-off grant suppresses the strobe in the same cycle; the pixel stays presented.
    assign plot     = pix_vld_q & gnt;
    assign vga_x    = vga_x_q;
    assign vga_y    = PADDLE_Y;
    assign colour   = colour_q;
    assign busy     = (state_q != S_IDLE);

endmodule
